reaction_display: RTL

REACTION_DISPLAY -- requirements
Module: reaction_display

---
 rtl/reaction_display.sv | 134 +++++++++++++
 1 files changed

// File: rtl/reaction_display.sv
// Reaction-time display: saturates a binary ms value to 9999, converts it to BCD by
// double-dabble, and multiplexes it onto a 4-digit common-anode 7-segment display.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits).
module reaction_display #(
    parameter int DIGIT_TICKS = 100000,
    parameter int VALUE_W     = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [VALUE_W-1:0] value,
    output logic               busy,
    output logic [3:0]         anode,
    output logic [6:0]         cathodes
);

    localparam int TICK_W = $clog2(DIGIT_TICKS);
    localparam int ITER_W = $clog2(VALUE_W + 1);
    // Narrow value ports can never exceed 9999, so the clamp degenerates to all-ones.
    localparam logic [VALUE_W-1:0] SAT_MAX = (VALUE_W >= 14) ? VALUE_W'(9999) : '1;

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t              state, state_nxt;
    logic [VALUE_W-1:0]  bin, bin_nxt, value_sat;
    logic [15:0]         bcd, bcd_nxt, disp, disp_nxt;
    logic [14:0]         bcd_adj;
    logic [ITER_W-1:0]   iter, iter_nxt;
    logic [TICK_W-1:0]   tick, tick_nxt;
    logic [1:0]          digit, digit_nxt;
    logic                blank_nxt;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Add-3 correction; the top bit is dropped because the following shift discards it.
    function automatic logic [14:0] add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r[14:0];
    endfunction

    assign busy = (state == CONVERT);

    always_comb begin
        state_nxt = state;
        bin_nxt   = bin;
        bcd_nxt   = bcd;
        iter_nxt  = iter;
        disp_nxt  = disp;
        value_sat = (value > SAT_MAX) ? SAT_MAX : value;
        bcd_adj   = add3(bcd);
        case (state)
            IDLE: begin
                if (load) begin
                    bin_nxt   = value_sat;
                    bcd_nxt   = '0;
                    iter_nxt  = '0;
                    state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_nxt, bin_nxt} = {bcd_adj, bin, 1'b0};
                iter_nxt = iter + 1'b1;
                if (iter == ITER_W'(VALUE_W - 1)) begin
                    disp_nxt  = {bcd_adj, bin[VALUE_W-1]};
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tick_nxt  = tick + 1'b1;
        digit_nxt = digit;
        if (tick == TICK_W'(DIGIT_TICKS - 1)) begin
            tick_nxt  = '0;
            digit_nxt = digit + 2'd1;
        end
`ifdef LEADING_ZERO_BLANK_EN
        case (digit_nxt)
            2'd3:    blank_nxt = (disp_nxt[15:12] == 4'd0);
            2'd2:    blank_nxt = (disp_nxt[15:8] == 8'd0);
            2'd1:    blank_nxt = (disp_nxt[15:4] == 12'd0);
            default: blank_nxt = 1'b0;
        endcase
`else
        blank_nxt = 1'b0;
`endif
    end

    // Outputs are registered from next-state values so they track digit/disp exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bin      <= '0;
            bcd      <= '0;
            iter     <= '0;
            disp     <= '0;
            tick     <= '0;
            digit    <= '0;
            anode    <= 4'b1110;
            cathodes <= 7'b1000000;
        end else begin
            state    <= state_nxt;
            bin      <= bin_nxt;
            bcd      <= bcd_nxt;
            iter     <= iter_nxt;
            disp     <= disp_nxt;
            tick     <= tick_nxt;
            digit    <= digit_nxt;
            anode    <= ~(4'b0001 << digit_nxt);
            cathodes <= blank_nxt ? 7'b1111111 : seg(disp_nxt[4*digit_nxt +: 4]);
        end
    end

endmodule
